mem_access_unit: RTL and testbench

Memory-stage access controller between the EX/MEM pipeline register and the byte-array data memory (128 bytes, big-endian, combinational word read, write on the rising edge of its write strobe).
- Accepts one load/store request at a time.
- Aligns addresses and checks ranges.
- Performs read-modify-write for sub-word stores.
- Sequences the read and write strobes so the memory never sees both at once and sees a clean write edge with stable address and data.
- Returns load data, aligned and extended, to the writeback path.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_lane_unit.sv | 76 +++++++
 rtl/mem_access_unit.sv | 107 ++++++++++
 tb/tb_mem_access_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access unit.
package mem_pkg;

    localparam int MEM_BYTES_DEF = 128;
    localparam int NUM_LANES     = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WPULSE,
        RESP
    } state_t;

    // Request fields held for the life of one transaction.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  lane;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of the memory-stage access unit.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    // Unit side.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output dm_read, dm_write, dm_addr, dm_wdata
    );

    // Pipeline plus data-memory side.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  dm_read, dm_write, dm_addr, dm_wdata
    );

endinterface

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: load extract/extend, store merge, and access error decode.
module mem_lane_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = 32
) (
    input  logic [1:0]        chk_size,
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              sgn,
    input  logic [31:0]       rword,
    input  logic [31:0]       wdata,
    output logic [31:0]       ld_data,
    output logic [31:0]       st_word,
    output logic              err
);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 1);

    logic [31:0]                      ld_sh;
    logic [NUM_LANES-1:0]             be;
    logic [NUM_LANES-1:0][7:0]        rb, wrep, mb;

    always_comb begin
        err = (chk_addr > MAX_ADDR);
        case (chk_size)
            SZ_BYTE: err = err;
            SZ_HALF: err = err | chk_addr[0];
            SZ_WORD: err = err | (|chk_addr[1:0]);
            default: err = 1'b1;
        endcase
    end

    // Big-endian: lane 0 is the MSB byte, so a lane's right shift is 8*(3-lane).
    always_comb begin
        ld_sh   = rword;
        ld_data = rword;
        case (size)
            SZ_BYTE: begin
                ld_sh   = rword >> {~lane, 3'b000};
                ld_data = {{24{sgn & ld_sh[7]}}, ld_sh[7:0]};
            end
            SZ_HALF: begin
                ld_sh   = rword >> {~lane[1], 4'b0000};
                ld_data = {{16{sgn & ld_sh[15]}}, ld_sh[15:0]};
            end
            default: ld_data = rword;
        endcase
    end

    always_comb begin
        rb = rword;
        case (size)
            SZ_BYTE: begin
                wrep = {NUM_LANES{wdata[7:0]}};
                be   = 4'b0001 << ~lane;
            end
            SZ_HALF: begin
                wrep = {2{wdata[15:0]}};
                be   = lane[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                wrep = wdata;
                be   = 4'b1111;
            end
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign mb[i] = be[i] ? wrep[i] : rb[i];
    end

    assign st_word = mb;

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: one load/store at a time, RMW for sub-word stores,
// read and write strobes sequenced so the memory sees a clean write edge.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    state_t      state;
    req_t        cap;
    logic        chk_err;
    logic [31:0] ld_data, st_word;

    // Error decode looks at the live request; extract/merge use captured fields and
    // the combinational memory word, which is only consumed while in RD.
    mem_lane_unit #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (ADDR_W)
    ) u_lane (
        .chk_size(bus.req_size),
        .chk_addr(bus.req_addr),
        .size    (cap.size),
        .lane    (cap.lane),
        .sgn     (cap.sgn),
        .rword   (bus.dm_rdata),
        .wdata   (cap.wdata),
        .ld_data (ld_data),
        .st_word (st_word),
        .err     (chk_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cap            <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.dm_read    <= 1'b0;
            bus.dm_write   <= 1'b0;
            bus.dm_addr    <= '0;
            bus.dm_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        cap <= '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed,
                                 lane: bus.req_addr[1:0], wdata: bus.req_wdata};
                        bus.req_ready <= 1'b0;
                        if (chk_err) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                            state          <= RESP;
                        end else begin
                            bus.dm_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            if (bus.req_we && bus.req_size == SZ_WORD) begin
                                bus.dm_wdata <= bus.req_wdata;
                                state        <= WSETUP;
                            end else begin
                                bus.dm_read <= 1'b1;
                                state       <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    bus.dm_read <= 1'b0;
                    if (cap.we) begin
                        bus.dm_wdata <= st_word;
                        state        <= WSETUP;
                    end else begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= ld_data;
                        state          <= RESP;
                    end
                end
                WSETUP: begin
                    bus.dm_write <= 1'b1;
                    state        <= WPULSE;
                end
                WPULSE: begin
                    bus.dm_write   <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                    state          <= RESP;
                end
                RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 128-byte big-endian memory model.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.MEM_BYTES(128), .ADDR_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [7:0]  mem [0:127] = '{default: 8'h00};
    logic [6:0]  ma;
    int          wr_cnt = 0;
    int          overlap = 0;
    int          unstable = 0;
    logic [31:0] wr_addr = '0, wr_data = '0, prev_addr = '0, prev_wdata = '0;

    assign ma = bus.dm_addr[6:0];
    assign bus.dm_rdata = (bus.dm_addr < 32'd128) ?
        {mem[{ma[6:2], 2'd0}], mem[{ma[6:2], 2'd1}], mem[{ma[6:2], 2'd2}], mem[{ma[6:2], 2'd3}]} : 32'h0;

    always @(negedge clk) begin
        if (bus.dm_read && bus.dm_write) overlap++;
        prev_addr  = bus.dm_addr;
        prev_wdata = bus.dm_wdata;
    end

    always @(posedge bus.dm_write) begin
        wr_cnt++;
        wr_addr = bus.dm_addr;
        wr_data = bus.dm_wdata;
        if (bus.dm_addr !== prev_addr || bus.dm_wdata !== prev_wdata) unstable++;
        if (bus.dm_addr < 32'd128) begin
            mem[{ma[6:2], 2'd0}] = bus.dm_wdata[31:24];
            mem[{ma[6:2], 2'd1}] = bus.dm_wdata[23:16];
            mem[{ma[6:2], 2'd2}] = bus.dm_wdata[15:8];
            mem[{ma[6:2], 2'd3}] = bus.dm_wdata[7:0];
        end
    end

    logic [31:0] rd;
    logic        er;
    int          lat, rdc, w0;

    // Issues one request; lat is the negedge count from accept to resp_valid (99 = none).
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] r, output logic e, output int l, output int rc);
        int w;
        l = 99; rc = 0; r = 'x; e = 1'bx; w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.dm_read) rc++;
            if (bus.resp_valid) begin l = n; r = bus.resp_rdata; e = bus.resp_err; break; end
        end
    endtask

    task automatic test_reset();
        #1;
        if (bus.req_ready !== 1'b1) begin $display("FAIL rst_ready got %b exp 1", bus.req_ready); n_fail++; end
        n_checks++;
        if ({bus.resp_valid, bus.resp_err, bus.dm_read, bus.dm_write} !== 4'b0) begin
            $display("FAIL rst_strobes got %b exp 0000", {bus.resp_valid, bus.resp_err, bus.dm_read, bus.dm_write}); n_fail++; end
        n_checks++;
        if ({bus.resp_rdata, bus.dm_addr, bus.dm_wdata} !== 96'h0) begin
            $display("FAIL rst_data got %h %h %h exp 0", bus.resp_rdata, bus.dm_addr, bus.dm_wdata); n_fail++; end
        n_checks++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_word();
        w0 = wr_cnt;
        do_req(1, 2'b10, 0, 32'h10, 32'h11223344, rd, er, lat, rdc);
        if (lat !== 3 || er !== 1'b0) begin $display("FAIL sw_lat got lat %0d err %b exp 3 0", lat, er); n_fail++; end
        n_checks++;
        if (wr_cnt - w0 !== 1 || rdc !== 0) begin $display("FAIL sw_writes got %0d rd %0d exp 1 0", wr_cnt - w0, rdc); n_fail++; end
        n_checks++;
        if (wr_addr !== 32'h10 || wr_data !== 32'h11223344) begin
            $display("FAIL sw_data got %h@%h exp 11223344@10", wr_data, wr_addr); n_fail++; end
        n_checks++;
        do_req(0, 2'b10, 0, 32'h10, 0, rd, er, lat, rdc);
        if (rd !== 32'h11223344 || er !== 1'b0 || lat !== 2) begin
            $display("FAIL lw got %h err %b lat %0d exp 11223344 0 2", rd, er, lat); n_fail++; end
        n_checks++;
    endtask

    task automatic test_byte_load();
        w0 = wr_cnt;
        do_req(0, 2'b00, 0, 32'h13, 0, rd, er, lat, rdc);
        if (rd !== 32'h44 || er !== 1'b0 || lat !== 2) begin
            $display("FAIL lbu got %h err %b lat %0d exp 00000044 0 2", rd, er, lat); n_fail++; end
        n_checks++;
        do_req(0, 2'b00, 1, 32'h10, 0, rd, er, lat, rdc);
        if (rd !== 32'h11 || er !== 1'b0 || lat !== 2) begin
            $display("FAIL lb got %h err %b lat %0d exp 00000011 0 2", rd, er, lat); n_fail++; end
        n_checks++;
        if (wr_cnt !== w0) begin $display("FAIL load_nowrite got %0d exp %0d", wr_cnt, w0); n_fail++; end
        n_checks++;
    endtask

    task automatic test_byte_store();
        w0 = wr_cnt;
        do_req(1, 2'b00, 0, 32'h11, 32'h000000AB, rd, er, lat, rdc);
        if (lat !== 4 || rdc !== 1 || er !== 1'b0) begin
            $display("FAIL sb_seq got lat %0d rd %0d err %b exp 4 1 0", lat, rdc, er); n_fail++; end
        n_checks++;
        if (wr_cnt - w0 !== 1 || wr_addr !== 32'h10 || wr_data !== 32'h11AB3344) begin
            $display("FAIL sb_data got %0d x %h@%h exp 1 x 11AB3344@10", wr_cnt - w0, wr_data, wr_addr); n_fail++; end
        n_checks++;
        do_req(0, 2'b10, 0, 32'h10, 0, rd, er, lat, rdc);
        if (rd !== 32'h11AB3344) begin $display("FAIL sb_readback got %h exp 11AB3344", rd); n_fail++; end
        n_checks++;
    endtask

    task automatic test_half();
        do_req(1, 2'b10, 0, 32'h20, 32'h1122F344, rd, er, lat, rdc);
        do_req(0, 2'b01, 1, 32'h22, 0, rd, er, lat, rdc);
        if (rd !== 32'hFFFFF344 || er !== 1'b0) begin $display("FAIL lh got %h err %b exp FFFFF344 0", rd, er); n_fail++; end
        n_checks++;
        do_req(0, 2'b01, 0, 32'h22, 0, rd, er, lat, rdc);
        if (rd !== 32'h0000F344) begin $display("FAIL lhu got %h exp 0000F344", rd); n_fail++; end
        n_checks++;
        do_req(0, 2'b01, 1, 32'h20, 0, rd, er, lat, rdc);
        if (rd !== 32'h00001122) begin $display("FAIL lh_hi got %h exp 00001122", rd); n_fail++; end
        n_checks++;
        w0 = wr_cnt;
        do_req(0, 2'b01, 1, 32'h21, 0, rd, er, lat, rdc);
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || rdc !== 0) begin
            $display("FAIL lh_misalign got err %b rd %h lat %0d rdc %0d exp 1 0 1 0", er, rd, lat, rdc); n_fail++; end
        n_checks++;
        // Half store at lane 2 of the same word.
        do_req(1, 2'b01, 0, 32'h22, 32'hDEAD5566, rd, er, lat, rdc);
        if (wr_data !== 32'h11225566 || lat !== 4) begin $display("FAIL sh got %h lat %0d exp 11225566 4", wr_data, lat); n_fail++; end
        n_checks++;
        if (wr_cnt - w0 !== 1) begin $display("FAIL err_nowrite got %0d exp 1", wr_cnt - w0); n_fail++; end
        n_checks++;
    endtask

    task automatic test_range();
        do_req(0, 2'b10, 0, 32'h7C, 0, rd, er, lat, rdc);
        if (er !== 1'b0 || lat !== 2 || rd !== 32'h0) begin $display("FAIL lw_7c got err %b lat %0d rd %h exp 0 2 0", er, lat, rd); n_fail++; end
        n_checks++;
        w0 = wr_cnt;
        do_req(0, 2'b10, 0, 32'h80, 0, rd, er, lat, rdc);
        if (er !== 1'b1 || lat !== 1 || rd !== 32'h0 || rdc !== 0) begin
            $display("FAIL lw_80 got err %b lat %0d rd %h rdc %0d exp 1 1 0 0", er, lat, rd, rdc); n_fail++; end
        n_checks++;
        do_req(1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, rd, er, lat, rdc);
        if (er !== 1'b1 || lat !== 1 || rd !== 32'h0 || wr_cnt !== w0) begin
            $display("FAIL size11 got err %b lat %0d rd %h wr %0d exp 1 1 0 %0d", er, lat, rd, wr_cnt, w0); n_fail++; end
        n_checks++;
        do_req(1, 2'b10, 0, 32'h32, 32'h12345678, rd, er, lat, rdc);
        if (er !== 1'b1 || wr_cnt !== w0) begin $display("FAIL sw_misalign got err %b wr %0d exp 1 %0d", er, wr_cnt, w0); n_fail++; end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        do_req(0, 2'b10, 0, 32'h10, 0, rd, er, lat, rdc);
        if (bus.req_ready !== 1'b0) begin $display("FAIL b2b_busy got %b exp 0", bus.req_ready); n_fail++; end
        n_checks++;
        @(negedge clk);
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            $display("FAIL b2b_idle got ready %b vld %b exp 1 0", bus.req_ready, bus.resp_valid); n_fail++; end
        n_checks++;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b1; bus.req_addr = 32'h11;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hFFFFFFAB) begin
            $display("FAIL b2b_lb got vld %b rd %h exp 1 FFFFFFAB", bus.resp_valid, bus.resp_rdata); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        w0 = wr_cnt;
        @(negedge clk);
        while (!bus.req_ready) @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h30; bus.req_wdata = 32'h000000AB;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        if (bus.dm_read !== 1'b1 || bus.dm_write !== 1'b0 || bus.dm_addr !== 32'h30) begin
            $display("FAIL rm_rd got rd %b wr %b addr %h exp 1 0 30", bus.dm_read, bus.dm_write, bus.dm_addr); n_fail++; end
        n_checks++;
        @(negedge clk);
        if (bus.dm_read !== 1'b0 || bus.dm_write !== 1'b0 || bus.dm_wdata !== 32'hAB000000) begin
            $display("FAIL rm_setup got rd %b wr %b wd %h exp 0 0 AB000000", bus.dm_read, bus.dm_write, bus.dm_wdata); n_fail++; end
        n_checks++;
        rst_n = 1'b0;
        #1;
        if (bus.req_ready !== 1'b1 || {bus.resp_valid, bus.dm_read, bus.dm_write} !== 3'b0 ||
            bus.dm_addr !== 32'h0 || bus.dm_wdata !== 32'h0) begin
            $display("FAIL rm_async got ready %b strobes %b addr %h wd %h exp 1 000 0 0",
                     bus.req_ready, {bus.resp_valid, bus.dm_read, bus.dm_write}, bus.dm_addr, bus.dm_wdata); n_fail++; end
        n_checks++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        if (bus.req_ready !== 1'b1 || wr_cnt !== w0) begin
            $display("FAIL rm_release got ready %b wr %0d exp 1 %0d", bus.req_ready, wr_cnt, w0); n_fail++; end
        n_checks++;
        do_req(0, 2'b10, 0, 32'h30, 0, rd, er, lat, rdc);
        if (rd !== 32'h0 || er !== 1'b0) begin $display("FAIL rm_nowrite got %h err %b exp 0 0", rd, er); n_fail++; end
        n_checks++;
    endtask

    task automatic test_invariants();
        if (overlap !== 0) begin $display("FAIL rd_wr_overlap got %0d exp 0", overlap); n_fail++; end
        n_checks++;
        if (unstable !== 0) begin $display("FAIL wr_stable got %0d exp 0", unstable); n_fail++; end
        n_checks++;
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        @(negedge clk);
        test_reset();
        test_word();
        test_byte_load();
        test_byte_store();
        test_half();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
